// File: rtl/aer_spike_frame_decoder.sv
// aer_spike_frame_decoder
//   Collects AER spike events into an N-bit spike frame and hands the frame
//   to the neuron array on every timestep tick.
//   Events pass through a small FIFO, one entry is decoded per cycle and ORed
//   into an accumulator. On a tick, the events already queued or accepted that
//   cycle are drained into the current frame. The frame is then published
//   through a single valid/ready output slot.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   ev_valid/ev_ready        event handshake (ev_ready = FIFO not full)
//   ev_addr, ev_bcast        neuron index / broadcast-to-all flag
//   tick                     end-of-timestep strobe
//   frame_valid/frame_ready  output slot handshake
//   frame                    spike vector, bit i = neuron i spiked
//   err_addr                 sticky, an out-of-range address was decoded
//   tick_drop                sticky, a tick arrived while not accumulating
//
// state | meaning
// ACCUM | decode events as they arrive, wait for tick
// DRAIN | decode the drain_cnt events that belong to the closing frame
// EMIT  | wait for the output slot, then publish acc as the new frame
module aer_spike_frame_decoder #(
    parameter int N     = 8,
    parameter int DEPTH = 4,
    localparam int M    = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ev_valid,
    output logic         ev_ready,
    input  logic [M-1:0] ev_addr,
    input  logic         ev_bcast,
    input  logic         tick,
    output logic         frame_valid,
    input  logic         frame_ready,
    output logic [N-1:0] frame,
    output logic         err_addr,
    output logic         tick_drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {ACCUM, DRAIN, EMIT} state_t;

    state_t        state, state_nxt;
    logic [M:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, drain_cnt, drain_nxt;
    logic [N-1:0]  acc;

    logic          push, pop, slot_free, load;
    logic [M:0]    head;
    logic          head_bcast;
    logic [M-1:0]  head_addr;
    logic          head_in_range;
    logic [N-1:0]  head_onehot;

    assign ev_ready      = (count != DEPTH_C);
    assign push          = ev_valid && ev_ready;
    assign pop           = ((state == ACCUM) || (state == DRAIN)) && (count != '0);
    assign slot_free     = !frame_valid || frame_ready;
    assign load          = (state == EMIT) && slot_free;

    assign head          = mem[rd_ptr];
    assign head_bcast    = head[M];
    assign head_addr     = head[M-1:0];
    assign head_in_range = (32'(head_addr) < N);
    assign head_onehot   = {{(N-1){1'b0}}, 1'b1} << head_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        drain_nxt = drain_cnt;
        case (state)
            ACCUM: begin
                if (tick) begin
                    // The tick-cycle push belongs to the frame being closed.
                    drain_nxt = count + CW'(push) - CW'(pop);
                    state_nxt = (drain_nxt == '0) ? EMIT : DRAIN;
                end
            end
            DRAIN: begin
                // drain_cnt never exceeds count, so pop is always true here.
                if (pop) begin
                    drain_nxt = drain_cnt - CW'(1);
                    if (drain_cnt == CW'(1)) state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (load) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {ev_bcast, ev_addr};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            acc         <= '0;
            frame       <= '0;
            frame_valid <= 1'b0;
            err_addr    <= 1'b0;
            tick_drop   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);

            if (load) begin
                acc <= '0;
            end else if (pop) begin
                if (head_bcast)         acc <= '1;
                else if (head_in_range) acc <= acc | head_onehot;
            end
            if (pop && !head_bcast && !head_in_range) err_addr <= 1'b1;

            if (load) begin
                frame       <= acc;
                frame_valid <= 1'b1;
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end

            if (tick && (state != ACCUM)) tick_drop <= 1'b1;
        end
    end

endmodule

// File: tb/tb_aer_spike_frame_decoder.sv
module tb_aer_spike_frame_decoder;

    localparam int N     = 6;
    localparam int DEPTH = 4;
    localparam int M     = $clog2(N);

    logic         clk = 1'b0;
    logic         rst;
    logic         ev_valid;
    logic         ev_ready;
    logic [M-1:0] ev_addr;
    logic         ev_bcast;
    logic         tick;
    logic         frame_valid;
    logic         frame_ready;
    logic [N-1:0] frame;
    logic         err_addr;
    logic         tick_drop;

    int tests = 0;
    int fails = 0;

    aer_spike_frame_decoder #(.N(N), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_addr     (ev_addr),
        .ev_bcast    (ev_bcast),
        .tick        (tick),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame       (frame),
        .err_addr    (err_addr),
        .tick_drop   (tick_drop)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_ev(input logic [M-1:0] a, input logic b);
        ev_valid = 1'b1;
        ev_addr  = a;
        ev_bcast = b;
        step();
        ev_valid = 1'b0;
        ev_bcast = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic wait_fv(input int maxc, output int n);
        n = 0;
        while (!frame_valid && n < maxc) begin
            step();
            n++;
        end
        if (!frame_valid) chk("fv_timeout", 32'(frame_valid), 32'd1);
    endtask

    initial begin
        int n, acc_n, nf;
        logic [N-1:0] last;

        rst = 1'b1; ev_valid = 1'b0; ev_addr = '0; ev_bcast = 1'b0;
        tick = 1'b0; frame_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_fv",    32'(frame_valid), 32'd0);
        chk("rst_ready", 32'(ev_ready),    32'd1);
        chk("rst_err",   32'(err_addr),    32'd0);
        chk("rst_drop",  32'(tick_drop),   32'd0);
        chk("rst_frame", 32'(frame),       32'd0);

        // 1: addresses 3,5,3 then tick; then an empty tick
        push_ev(3'd3, 1'b0);
        push_ev(3'd5, 1'b0);
        push_ev(3'd3, 1'b0);
        do_tick();
        wait_fv(10, n);
        chk("t1_frame", 32'(frame), 32'h28);
        step();
        chk("t1_fv_pulse", 32'(frame_valid), 32'd0);
        do_tick();
        wait_fv(10, n);
        chk("t1_empty_frame", 32'(frame), 32'h00);
        chk("t1_empty_lat", 32'(n + 1), 32'd2);
        step();

        // 2: out-of-range address then broadcast
        push_ev(3'd7, 1'b0);
        push_ev(3'd0, 1'b1);
        do_tick();
        wait_fv(10, n);
        chk("t2_bcast_frame", 32'(frame), 32'h3F);
        chk("t2_err", 32'(err_addr), 32'd1);
        step();
        push_ev(3'd2, 1'b0);
        do_tick();
        wait_fv(10, n);
        chk("t2_addr2_frame", 32'(frame), 32'h04);
        chk("t2_err_sticky", 32'(err_addr), 32'd1);
        step();

        // 3: event in the tick cycle, another one cycle later
        ev_valid = 1'b1; ev_addr = 3'd1; tick = 1'b1;
        step();
        tick = 1'b0; ev_addr = 3'd4;
        chk("t3_fv_lat1", 32'(frame_valid), 32'd0);
        step();
        ev_valid = 1'b0;
        chk("t3_fv_lat2", 32'(frame_valid), 32'd0);
        step();
        chk("t3_fv_lat3", 32'(frame_valid), 32'd1);
        chk("t3_frame1", 32'(frame), 32'h02);
        do_tick();
        wait_fv(10, n);
        chk("t3_frame2", 32'(frame), 32'h10);

        // 4: backpressure from a stalled output slot
        step();
        frame_ready = 1'b0;
        push_ev(3'd0, 1'b0);
        do_tick();
        wait_fv(10, n);
        chk("t4_frameA", 32'(frame), 32'h01);
        push_ev(3'd1, 1'b0);
        step();
        do_tick();
        acc_n = 0;
        for (int i = 0; i < 6; i++) begin
            ev_valid = 1'b1;
            ev_addr  = 3'(i);
            if (ev_ready) acc_n++;
            step();
        end
        ev_valid = 1'b0;
        chk("t4_accepts", 32'(acc_n), 32'd4);
        chk("t4_ready_low", 32'(ev_ready), 32'd0);
        chk("t4_A_held_fv", 32'(frame_valid), 32'd1);
        chk("t4_A_held", 32'(frame), 32'h01);
        frame_ready = 1'b1;
        step();
        chk("t4_B_fv", 32'(frame_valid), 32'd1);
        chk("t4_frameB", 32'(frame), 32'h02);
        do_tick();
        wait_fv(10, n);
        chk("t4_frameC", 32'(frame), 32'h0F);

        // 5: tick while draining
        frame_ready = 1'b0;
        do_tick();
        push_ev(3'd0, 1'b0);
        push_ev(3'd2, 1'b0);
        push_ev(3'd4, 1'b0);
        chk("t5_drop_before", 32'(tick_drop), 32'd0);
        frame_ready = 1'b1;
        step();
        tick = 1'b1;
        step();
        step();
        tick = 1'b0;
        chk("t5_drop", 32'(tick_drop), 32'd1);
        nf = 0;
        last = '0;
        for (int i = 0; i < 8; i++) begin
            if (frame_valid) begin
                nf++;
                last = frame;
            end
            step();
        end
        chk("t5_nframes", 32'(nf), 32'd1);
        chk("t5_frame", 32'(last), 32'h15);

        // 6: reset while draining with a pending frame
        frame_ready = 1'b0;
        do_tick();
        step();
        do_tick();
        push_ev(3'd3, 1'b0);
        push_ev(3'd5, 1'b0);
        push_ev(3'd1, 1'b0);
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("t6_pending", 32'(frame_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_fv", 32'(frame_valid), 32'd0);
        chk("t6_ready", 32'(ev_ready), 32'd1);
        chk("t6_err", 32'(err_addr), 32'd0);
        chk("t6_drop", 32'(tick_drop), 32'd0);
        frame_ready = 1'b1;
        do_tick();
        wait_fv(10, n);
        chk("t6_frame", 32'(frame), 32'h00);
        chk("t6_lat", 32'(n + 1), 32'd2);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aer_spike_frame_decoder.md
Name: aer_spike_frame_decoder

Overview:
- Parametrised successor to the combinational address-to-one-hot decoder.
- Accepts AER spike events (neuron address, or a broadcast flag) through a valid/ready FIFO, decodes one event per cycle and ORs it into an N-bit spike accumulator.
- On each timestep tick, the accumulated spike frame is closed and handed to the crossbar/neuron array through a valid/ready output slot.
- Sits between the inter-layer AER bus and a layer's spike-input vector.

Parameters:
- N, 8: number of neurons, which is also the frame width. Must be ≥ 2.
- DEPTH, 4: event FIFO depth. Power of two, ≥ 2.
- M, $clog2(N): localparam, event address width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- ev_valid  input  1  event offered.
- ev_ready  output  1  event slot available; equals !fifo_full.
- ev_addr  input  M  target neuron index.
- ev_bcast  input  1  broadcast event; ev_addr is ignored.
- tick  input  1  single-cycle end-of-timestep strobe.
- frame_valid  output  1  frame holds an unconsumed spike vector.
- frame_ready  input  1  consumer takes the frame.
- frame  output  N  spike vector, bit i = neuron i spiked.
- err_addr  output  1  sticky: an event with ev_addr ≥ N was seen.
- tick_drop  output  1  sticky: a tick arrived while not in ACCUM.

Behaviour:
- Clocking and reset:
  - Single clock; all state is registered.
  - rst clears FIFO pointers and count, acc, frame, frame_valid, err_addr, tick_drop and drain_cnt, and sets state to ACCUM.
  - Reset mid-operation discards all queued events and any pending frame. No frame_valid appears until a new tick completes.
- Event FIFO:
  - Push when ev_valid && ev_ready.
  - ev_ready = (count != DEPTH) in every state, computed from registered count. There is no pass-through push when full, even if a pop occurs that cycle.
  - Each entry stores {bcast, addr}.
- Decode on pop:
  - Broadcast: acc <= all ones.
  - Otherwise, if addr < N: acc <= acc | (1 << addr).
  - Otherwise: no acc change, and err_addr <= 1.
  - Duplicate addresses are idempotent.
- FSM, three states:
  - ACCUM: pop one entry per cycle when the FIFO is non-empty. On tick, compute drain_cnt = count + push − pop for that cycle. This places the tick-cycle event in the current frame.
    - If drain_cnt == 0, go to EMIT; otherwise go to DRAIN.
  - DRAIN: pop one entry per cycle and decrement drain_cnt. Go to EMIT after the entry that brings drain_cnt to 0 is popped.
    - Events pushed after the tick stay queued for the next frame.
  - EMIT: no pops.
    - The output slot is free when !frame_valid || frame_ready.
    - When the slot is free: frame <= acc, frame_valid <= 1, acc <= 0, go to ACCUM. Otherwise stay in EMIT.
    - The FIFO keeps accepting until full, which provides backpressure.
- Output slot:
  - frame_valid && frame_ready with no new load in that cycle: frame_valid <= 0, and frame keeps its last value.
  - A load and a consume in the same cycle leaves frame_valid = 1 with the new frame.
- Ticks outside ACCUM:
  - A tick while in DRAIN or EMIT is ignored (no extra frame) and sets tick_drop <= 1.
- Latency:
  - Tick at cycle t in ACCUM, no queued or accepted events, slot free: EMIT at t+1, frame_valid = 1 at t+2.
  - Each entry to drain adds 1 cycle.
  - Accepted event to acc update: 1 cycle minimum (FIFO write, then pop).
- Arithmetic:
  - count is $clog2(DEPTH)+1 bits wide.
  - drain_cnt is the same width and is never greater than DEPTH.
  - Pointers wrap modulo DEPTH.

Test Plan:
1. N=8, DEPTH=4, frame_ready=1. Events at addresses 3, 5, 3, then tick → one frame = 8'b0010_1000 with frame_valid for 1 cycle. A second tick with no events → frame = 8'h00 with frame_valid.
2. N=6. Event with addr 7, then a bcast event, then tick → frame = 6'b111111 and err_addr = 1 (stays 1 until rst). A later addr-2 event with tick → frame = 6'b000100.
3. Event addr 1 in the same cycle as tick, event addr 4 one cycle later, next tick → first frame = 8'h02, second frame = 8'h10. Tick-to-frame_valid latency = 3 cycles for the first frame.
4. frame_ready=0 with frame A pending. Tick, then offer 6 events → FSM held in EMIT; ev_ready drops after 4 accepts. Raise frame_ready → frame A consumed, frame B loaded the same cycle (frame_valid stays 1), and the 4 queued events drain into frame C.
5. Tick while in DRAIN (3 queued events) → exactly one frame emitted and tick_drop = 1.
6. rst asserted in DRAIN with 2 events queued and a frame pending → next cycle: frame_valid = 0, ev_ready = 1, err_addr = 0, tick_drop = 0. A subsequent tick yields frame = 0.
